// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, drives the combinational
// instruction memory and fills the IF/ID register. Handles stalls,
// redirects with squash, and a halt -> drain -> halted -> restart sequence.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset; IF/ID empty, waits for start (loads RESET_PC)
// RUN      | one fetch action per edge: halt > redirect > stall > normal
// DRAIN    | fetch stopped, downstream stages empty out for DRAIN_CYCLES
// HALTED   | everything frozen; start resumes at the held pc
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] NOP_INSTR    = 16'h0000,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus1,
    output logic        ifid_valid,
    output logic [1:0]  state,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_DRAIN  = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    // Drain ends on the edge where the counter already shows the last cycle.
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t      st;
    logic [15:0] pc;
    logic [3:0]  drain_cnt;

    // Memory address is the live pc: zero extra fetch latency.
    assign imem_addr = pc;
    assign state     = st;

    // Sequencer FSM, PC and IF/ID register with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st            <= S_IDLE;
            pc            <= RESET_PC;
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= 16'h0000;
            ifid_pc_plus1 <= 16'h0000;
            ifid_valid    <= 1'b0;
            fetch_count   <= 16'h0000;
            drain_cnt     <= 4'd0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (start) begin
                        st <= S_RUN;
                        pc <= RESET_PC;
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        ifid_instr    <= NOP_INSTR;
                        ifid_pc       <= 16'h0000;
                        ifid_pc_plus1 <= 16'h0000;
                        ifid_valid    <= 1'b0;
                        drain_cnt     <= 4'd0;
                        st            <= S_DRAIN;
                    end else if (redirect) begin
                        // The word fetched this cycle is on the wrong path.
                        pc            <= redirect_pc;
                        ifid_instr    <= NOP_INSTR;
                        ifid_pc       <= 16'h0000;
                        ifid_pc_plus1 <= 16'h0000;
                        ifid_valid    <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr    <= imem_instr;
                        ifid_pc       <= pc;
                        ifid_pc_plus1 <= pc + 16'd1;
                        ifid_valid    <= 1'b1;
                        pc            <= pc + 16'd1;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 4'd1;
                    if (drain_cnt == DRAIN_LAST) begin
                        st <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        st <= S_RUN;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// run, all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_sequencer;

    localparam logic [15:0] RESET_PC     = 16'h0000;
    localparam logic [15:0] NOP_INSTR    = 16'h0000;
    localparam int          DRAIN_CYCLES = 3;

    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_HALTED = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stall = 1'b0, redirect = 1'b0, halt_req = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_addr, imem_instr;
    logic [15:0] ifid_instr, ifid_pc, ifid_pc_plus1, fetch_count;
    logic        ifid_valid;
    logic [1:0]  state;

    logic [15:0] mem [0:65535];
    assign imem_instr = mem[imem_addr];

    int vectors = 0;
    int miscompares = 0;

    // behavioural model
    int          m_state;
    logic [15:0] m_pc, m_instr, m_ipc, m_ipc1;
    logic        m_valid;
    int          m_count;
    int          drain_left;

    fetch_sequencer #(
        .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1),
        .ifid_valid(ifid_valid), .state(state), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = S_IDLE; m_pc = RESET_PC; m_instr = NOP_INSTR;
        m_ipc = 16'h0000; m_ipc1 = 16'h0000; m_valid = 1'b0;
        m_count = 0; drain_left = 0;
    endtask

    task automatic model_bubble();
        m_instr = NOP_INSTR; m_ipc = 16'h0000; m_ipc1 = 16'h0000; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sl, input logic rd,
                              input logic [15:0] rp, input logic hr);
        case (m_state)
            S_IDLE: if (st) begin m_state = S_RUN; m_pc = RESET_PC; end
            S_RUN: begin
                if (hr) begin
                    model_bubble(); drain_left = DRAIN_CYCLES; m_state = S_DRAIN;
                end else if (rd) begin
                    model_bubble(); m_pc = rp;
                end else if (!sl) begin
                    m_instr = mem[m_pc]; m_ipc = m_pc; m_ipc1 = m_pc + 16'd1;
                    m_valid = 1'b1; m_pc = m_pc + 16'd1;
                    if (m_count < 65535) m_count++;
                end
            end
            S_DRAIN: begin
                drain_left--;
                if (drain_left == 0) m_state = S_HALTED;
            end
            default: if (st) m_state = S_RUN;
        endcase
    endtask

    // Drive inputs between edges, advance one edge, update model, settle.
    task automatic tick(input logic st, input logic sl, input logic rd,
                        input logic [15:0] rp, input logic hr);
        start = st; stall = sl; redirect = rd; redirect_pc = rp; halt_req = hr;
        @(posedge clk);
        model_step(st, sl, rd, rp, hr);
        #1;
    endtask

    task automatic do_reset();
        start = 0; stall = 0; redirect = 0; halt_req = 0; redirect_pc = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({state, imem_addr, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, fetch_count}
            !== {2'b00, RESET_PC, NOP_INSTR, 16'h0, 16'h0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_values got st=%b addr=%h i=%h pc=%h p1=%h v=%b cnt=%h exp all zero/IDLE",
                     state, imem_addr, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, fetch_count);
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (state !== 2'b00 || ifid_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold got st=%b v=%b exp st=00 v=0", state, ifid_valid);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        tick(1, 0, 0, 0, 0);
        vectors++;
        if (state !== 2'b01 || ifid_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL start_to_run got st=%b v=%b addr=%h exp st=01 v=0 addr=%h",
                     state, ifid_valid, imem_addr, RESET_PC);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0);
            vectors++;
            if (ifid_instr !== mem[i] || ifid_pc !== 16'(i) || ifid_pc_plus1 !== 16'(i + 1)
                || ifid_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL seq_fetch%0d got i=%h pc=%h p1=%h v=%b exp i=%h pc=%h p1=%h v=1",
                         i, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, mem[i], 16'(i), 16'(i + 1));
            end
        end
        vectors++;
        if (fetch_count !== 16'd4) begin
            miscompares++;
            $display("FAIL seq_count got %0d exp 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 1, 0, 0, 0);
            vectors++;
            if (ifid_instr !== mem[1] || ifid_pc !== 16'd1 || imem_addr !== 16'd2
                || fetch_count !== 16'd2) begin
                miscompares++;
                $display("FAIL stall_hold%0d got i=%h pc=%h addr=%h cnt=%0d exp i=%h pc=0001 addr=0002 cnt=2",
                         i, ifid_instr, ifid_pc, imem_addr, fetch_count, mem[1]);
            end
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (ifid_instr !== mem[2] || ifid_pc !== 16'd2) begin
            miscompares++;
            $display("FAIL stall_release got i=%h pc=%h exp i=%h pc=0002", ifid_instr, ifid_pc, mem[2]);
        end
    endtask

    task automatic test_redirect_stall();
        tick(0, 1, 1, 16'h0040, 0);
        vectors++;
        if (ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR || ifid_pc !== 16'h0
            || imem_addr !== 16'h0040) begin
            miscompares++;
            $display("FAIL redirect_squash got v=%b i=%h pc=%h addr=%h exp v=0 i=%h pc=0000 addr=0040",
                     ifid_valid, ifid_instr, ifid_pc, imem_addr, NOP_INSTR);
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (ifid_pc !== 16'h0040 || ifid_instr !== mem[16'h0040] || ifid_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL redirect_target got pc=%h i=%h v=%b exp pc=0040 i=%h v=1",
                     ifid_pc, ifid_instr, ifid_valid, mem[16'h0040]);
        end
    endtask

    task automatic test_halt();
        logic [15:0] held;
        held = imem_addr;
        tick(0, 0, 1, 16'h1234, 1);
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            vectors++;
            if (state !== 2'b10 || ifid_valid !== 1'b0 || imem_addr !== held) begin
                miscompares++;
                $display("FAIL drain%0d got st=%b v=%b addr=%h exp st=10 v=0 addr=%h",
                         i, state, ifid_valid, imem_addr, held);
            end
            tick(1, 1, 1, 16'h5555, 1);
        end
        vectors++;
        if (state !== 2'b11 || ifid_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halted got st=%b v=%b exp st=11 v=0", state, ifid_valid);
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (state !== 2'b11 || imem_addr !== held) begin
            miscompares++;
            $display("FAIL halted_hold got st=%b addr=%h exp st=11 addr=%h", state, imem_addr, held);
        end
        tick(1, 0, 0, 0, 0);
        vectors++;
        if (state !== 2'b01 || imem_addr !== held) begin
            miscompares++;
            $display("FAIL restart got st=%b addr=%h exp st=01 addr=%h", state, imem_addr, held);
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (ifid_pc !== held || ifid_valid !== 1'b1 || ifid_instr !== mem[held]) begin
            miscompares++;
            $display("FAIL resume_fetch got pc=%h v=%b i=%h exp pc=%h v=1 i=%h",
                     ifid_pc, ifid_valid, ifid_instr, held, mem[held]);
        end
    endtask

    task automatic test_wrap();
        tick(0, 0, 1, 16'hFFFF, 0);
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (ifid_pc !== 16'hFFFF || ifid_pc_plus1 !== 16'h0000 || ifid_instr !== mem[16'hFFFF]) begin
            miscompares++;
            $display("FAIL wrap_last got pc=%h p1=%h i=%h exp pc=ffff p1=0000 i=%h",
                     ifid_pc, ifid_pc_plus1, ifid_instr, mem[16'hFFFF]);
        end
        tick(0, 0, 0, 0, 0);
        vectors++;
        if (ifid_pc !== 16'h0000 || ifid_pc_plus1 !== 16'h0001 || imem_addr !== 16'h0001) begin
            miscompares++;
            $display("FAIL wrap_next got pc=%h p1=%h addr=%h exp pc=0000 p1=0001 addr=0001",
                     ifid_pc, ifid_pc_plus1, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        tick(0, 0, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({state, imem_addr, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, fetch_count}
            !== {2'b00, RESET_PC, NOP_INSTR, 16'h0, 16'h0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL async_reset got st=%b addr=%h i=%h pc=%h p1=%h v=%b cnt=%h exp all zero/IDLE",
                     state, imem_addr, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, fetch_count);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_saturate();
        do_reset();
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) tick(0, 0, 0, 0, 0);
        vectors++;
        if (fetch_count !== 16'hFFFF || 32'(fetch_count) !== m_count) begin
            miscompares++;
            $display("FAIL count_saturate got %h exp ffff", fetch_count);
        end
        vectors++;
        if (ifid_pc !== m_ipc || imem_addr !== m_pc) begin
            miscompares++;
            $display("FAIL long_run_pc got pc=%h addr=%h exp pc=%h addr=%h", ifid_pc, imem_addr, m_ipc, m_pc);
        end
    endtask

    task automatic test_random();
        logic st, sl, rd, hr;
        logic [15:0] rp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom % 6) == 0;
            sl = ($urandom % 4) == 0;
            rd = ($urandom % 8) == 0;
            hr = ($urandom % 40) == 0;
            rp = 16'($urandom);
            tick(st, sl, rd, rp, hr);
            vectors++;
            if (imem_addr !== m_pc || ifid_instr !== m_instr || ifid_pc !== m_ipc
                || ifid_pc_plus1 !== m_ipc1 || ifid_valid !== m_valid
                || state !== 2'(m_state) || fetch_count !== 16'(m_count)) begin
                miscompares++;
                $display("FAIL random%0d got addr=%h i=%h pc=%h p1=%h v=%b st=%b cnt=%h exp addr=%h i=%h pc=%h p1=%h v=%b st=%b cnt=%h",
                         n, imem_addr, ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, state, fetch_count,
                         m_pc, m_instr, m_ipc, m_ipc1, m_valid, 2'(m_state), 16'(m_count));
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[0] = 16'hA00A; mem[1] = 16'hB00B; mem[2] = 16'hC00C; mem[3] = 16'hD00D;
        model_reset();
        test_reset();
        test_sequence();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
